// File: rtl/hs_perf_monitor.sv
// Per-channel HLS handshake performance monitor. Tracks ap_start/ap_done/ap_continue
// on each channel and accumulates saturating invocation, latency, stall and iteration statistics.
module hs_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [NUM_CH-1:0] ch_start,
    input  logic [NUM_CH-1:0] ch_ready,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_continue,
    input  logic [NUM_CH-1:0] ch_iter,
    input  logic [NUM_CH-1:0] ch_stall,
    input  logic              clr,
    input  logic              freeze,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              any_sat
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_CONT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns {blocked, next}: increments when en, holding at all-ones; blocked marks a lost step.
    function automatic logic [CNT_W:0] sat_step(input logic en, input logic [CNT_W-1:0] v);
        logic [CNT_W:0] r;
        if (!en) begin
            r = {1'b0, v};
        end else if (v == CNT_MAX) begin
            r = {1'b1, v};
        end else begin
            r = {1'b0, v + CNT_ONE};
        end
        return r;
    endfunction

    state_t           state_q [NUM_CH];
    state_t           state_d [NUM_CH];
    logic [CNT_W-1:0] lat_q   [NUM_CH];
    logic [CNT_W-1:0] lat_d   [NUM_CH];
    logic [CNT_W-1:0] inv_q   [NUM_CH];
    logic [CNT_W-1:0] inv_d   [NUM_CH];
    logic [CNT_W-1:0] last_q  [NUM_CH];
    logic [CNT_W-1:0] last_d  [NUM_CH];
    logic [CNT_W-1:0] min_q   [NUM_CH];
    logic [CNT_W-1:0] min_d   [NUM_CH];
    logic [CNT_W-1:0] max_q   [NUM_CH];
    logic [CNT_W-1:0] max_d   [NUM_CH];
    logic [CNT_W-1:0] act_q   [NUM_CH];
    logic [CNT_W-1:0] act_d   [NUM_CH];
    logic [CNT_W-1:0] stl_q   [NUM_CH];
    logic [CNT_W-1:0] stl_d   [NUM_CH];
    logic [CNT_W-1:0] itr_q   [NUM_CH];
    logic [CNT_W-1:0] itr_d   [NUM_CH];
    logic [NUM_CH-1:0] sat_q, sat_d;
    logic             any_sat_q, any_sat_d;
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    logic [NUM_CH-1:0] cap_s, lat_ovf_s;
    logic [NUM_CH-1:0] inv_ovf_s, act_ovf_s, stl_ovf_s, itr_ovf_s;
    logic [CNT_W-1:0]  cap_val_s [NUM_CH];
    logic [CNT_W-1:0]  inv_inc_s [NUM_CH];
    logic [CNT_W-1:0]  act_inc_s [NUM_CH];
    logic [CNT_W-1:0]  stl_inc_s [NUM_CH];
    logic [CNT_W-1:0]  itr_inc_s [NUM_CH];
    logic [CNT_W-1:0]  sel_word_s [NUM_CH];
    logic [CNT_W-1:0]  rd_word_s;

    // Handshake FSM and running latency; keeps tracking through freeze and clr
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]   = state_q[c];
            lat_d[c]     = lat_q[c];
            cap_s[c]     = 1'b0;
            cap_val_s[c] = CNT_ONE;
            lat_ovf_s[c] = 1'b0;
            case (state_q[c])
                ST_IDLE: begin
                    if (ch_start[c]) begin
                        lat_d[c] = CNT_ONE;
                        cap_s[c] = ch_done[c];
                        if (ch_done[c]) begin
                            state_d[c] = ch_continue[c] ? ST_IDLE : ST_WAIT_CONT;
                        end else begin
                            state_d[c] = ST_RUN;
                        end
                    end else begin
                        state_d[c] = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    {lat_ovf_s[c], lat_d[c]} = sat_step(1'b1, lat_q[c]);
                    cap_val_s[c] = lat_d[c];
                    cap_s[c]     = ch_done[c];
                    if (ch_done[c]) begin
                        state_d[c] = ch_continue[c] ? ST_IDLE : ST_WAIT_CONT;
                    end else begin
                        state_d[c] = ST_RUN;
                    end
                end
                ST_WAIT_CONT: begin
                    state_d[c] = (ch_done[c] && ch_continue[c]) ? ST_IDLE : ST_WAIT_CONT;
                end
                default: begin
                    state_d[c] = ST_IDLE;
                end
            endcase
        end
    end

    // Statistics update: clr beats every same-cycle event, freeze holds everything
    always_comb begin
        any_sat_d = |sat_q;
        sat_d     = sat_q;
        for (int c = 0; c < NUM_CH; c++) begin
            {inv_ovf_s[c], inv_inc_s[c]} = sat_step(cap_s[c], inv_q[c]);
            {act_ovf_s[c], act_inc_s[c]} = sat_step((state_q[c] != ST_IDLE) || ch_start[c], act_q[c]);
            {stl_ovf_s[c], stl_inc_s[c]} = sat_step(ch_stall[c] && (state_q[c] == ST_RUN), stl_q[c]);
            {itr_ovf_s[c], itr_inc_s[c]} = sat_step(ch_iter[c], itr_q[c]);
            if (clr) begin
                inv_d[c]  = CNT_ZERO;
                last_d[c] = CNT_ZERO;
                min_d[c]  = CNT_MAX;
                max_d[c]  = CNT_ZERO;
                act_d[c]  = CNT_ZERO;
                stl_d[c]  = CNT_ZERO;
                itr_d[c]  = CNT_ZERO;
                sat_d[c]  = 1'b0;
            end else if (freeze) begin
                inv_d[c]  = inv_q[c];
                last_d[c] = last_q[c];
                min_d[c]  = min_q[c];
                max_d[c]  = max_q[c];
                act_d[c]  = act_q[c];
                stl_d[c]  = stl_q[c];
                itr_d[c]  = itr_q[c];
                sat_d[c]  = sat_q[c];
            end else begin
                inv_d[c]  = inv_inc_s[c];
                last_d[c] = cap_s[c] ? cap_val_s[c] : last_q[c];
                min_d[c]  = (cap_s[c] && (cap_val_s[c] < min_q[c])) ? cap_val_s[c] : min_q[c];
                max_d[c]  = (cap_s[c] && (cap_val_s[c] > max_q[c])) ? cap_val_s[c] : max_q[c];
                act_d[c]  = act_inc_s[c];
                stl_d[c]  = stl_inc_s[c];
                itr_d[c]  = itr_inc_s[c];
                sat_d[c]  = sat_q[c] | inv_ovf_s[c] | act_ovf_s[c] | stl_ovf_s[c]
                          | itr_ovf_s[c] | lat_ovf_s[c];
            end
        end
    end

    // Read mux over pre-update values; unmatched channel numbers leave the word at zero
    always_comb begin
        rd_word_s = CNT_ZERO;
        for (int c = 0; c < NUM_CH; c++) begin
            case (rd_sel)
                3'd0:    sel_word_s[c] = inv_q[c];
                3'd1:    sel_word_s[c] = last_q[c];
                3'd2:    sel_word_s[c] = min_q[c];
                3'd3:    sel_word_s[c] = max_q[c];
                3'd4:    sel_word_s[c] = act_q[c];
                3'd5:    sel_word_s[c] = stl_q[c];
                3'd6:    sel_word_s[c] = itr_q[c];
                3'd7:    sel_word_s[c] = {{(CNT_W-4){1'b0}}, ch_ready[c], sat_q[c], state_q[c]};
                default: sel_word_s[c] = CNT_ZERO;
            endcase
            rd_word_s = (rd_ch == CH_W'(c)) ? sel_word_s[c] : rd_word_s;
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? rd_word_s : rd_data_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
                lat_q[c]   <= CNT_ZERO;
                inv_q[c]   <= CNT_ZERO;
                last_q[c]  <= CNT_ZERO;
                min_q[c]   <= CNT_MAX;
                max_q[c]   <= CNT_ZERO;
                act_q[c]   <= CNT_ZERO;
                stl_q[c]   <= CNT_ZERO;
                itr_q[c]   <= CNT_ZERO;
            end
            sat_q      <= {NUM_CH{1'b0}};
            any_sat_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= CNT_ZERO;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                lat_q[c]   <= lat_d[c];
                inv_q[c]   <= inv_d[c];
                last_q[c]  <= last_d[c];
                min_q[c]   <= min_d[c];
                max_q[c]   <= max_d[c];
                act_q[c]   <= act_d[c];
                stl_q[c]   <= stl_d[c];
                itr_q[c]   <= itr_d[c];
            end
            sat_q      <= sat_d;
            any_sat_q  <= any_sat_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign any_sat  = any_sat_q;

endmodule

// File: tb/tb_hs_perf_monitor.sv
// Bench for hs_perf_monitor: directed handshake scenarios plus random traffic, checked every
// cycle against a cycle-count based model; a 16-bit instance covers counter saturation.
`timescale 1ns/1ps
module tb_hs_perf_monitor;
    localparam int     NCH  = 4;
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  start, ready, done, cont, iter, stall;
    logic        clr, freeze, rd_en;
    logic [3:0]  rd_ch;
    logic [2:0]  rd_sel;
    logic        rd_valid, any_sat;
    logic [31:0] rd_data;

    logic [3:0]  b_start, b_done;
    logic [3:0]  b_zero = 4'h0;
    logic [3:0]  b_ones = 4'hF;
    logic        b_clr, b_freeze, b_rd_en;
    logic [3:0]  b_rd_ch;
    logic [2:0]  b_rd_sel;
    logic        b_rd_valid, b_any_sat;
    logic [15:0] b_rd_data;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hs_perf_monitor #(.NUM_CH(NCH), .CNT_W(32), .CH_W(4)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .ch_start(start), .ch_ready(ready), .ch_done(done),
        .ch_continue(cont), .ch_iter(iter), .ch_stall(stall), .clr(clr), .freeze(freeze),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_data(rd_data),
        .any_sat(any_sat)
    );

    hs_perf_monitor #(.NUM_CH(NCH), .CNT_W(16), .CH_W(4)) dut16 (
        .ap_clk(clk), .ap_rst_n(rst_n), .ch_start(b_start), .ch_ready(b_zero), .ch_done(b_done),
        .ch_continue(b_ones), .ch_iter(b_zero), .ch_stall(b_zero), .clr(b_clr), .freeze(b_freeze),
        .rd_en(b_rd_en), .rd_ch(b_rd_ch), .rd_sel(b_rd_sel), .rd_valid(b_rd_valid),
        .rd_data(b_rd_data), .any_sat(b_any_sat)
    );

    // Model: phase per channel (0 idle, 1 running, 2 waiting for continue); latency from cycle stamps
    int     m_ph  [NCH];
    longint m_t0  [NCH];
    longint m_inv [NCH];
    longint m_last[NCH];
    longint m_min [NCH];
    longint m_max [NCH];
    longint m_act [NCH];
    longint m_stl [NCH];
    longint m_itr [NCH];
    bit     m_sat [NCH];
    longint cyc = 0;
    bit          exp_valid = 1'b0;
    bit          exp_any = 1'b0;
    logic [31:0] exp_data = 32'h0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic model_clear(input int c);
        m_inv[c] = 0; m_last[c] = 0; m_min[c] = MAXV; m_max[c] = 0;
        m_act[c] = 0; m_stl[c] = 0; m_itr[c] = 0; m_sat[c] = 1'b0;
    endtask

    function automatic longint m_word(input int ch, input int sel, input bit rdy);
        if (ch >= NCH) return 0;
        case (sel)
            0: return m_inv[ch];
            1: return m_last[ch];
            2: return m_min[ch];
            3: return m_max[ch];
            4: return m_act[ch];
            5: return m_stl[ch];
            6: return m_itr[ch];
            7: return longint'(m_ph[ch]) + (m_sat[ch] ? 4 : 0) + (rdy ? 8 : 0);
            default: return 0;
        endcase
    endfunction

    task automatic model_eval();
        int nph, rc;
        bit cap, lovf, act, stl, rdy, any_now;
        longint val, dt, w;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_ph[c] = 0; m_t0[c] = 0; model_clear(c);
            end
            exp_valid = 1'b0; exp_data = 32'h0; exp_any = 1'b0;
        end else begin
            any_now = 1'b0;
            for (int c = 0; c < NCH; c++) any_now |= m_sat[c];
            exp_any = any_now;
            exp_valid = rd_en;
            if (rd_en) begin
                rc = int'(rd_ch);
                rdy = 1'b0;
                if (rc < NCH) rdy = ready[rc];
                w = m_word(rc, int'(rd_sel), rdy);
                exp_data = w[31:0];
            end
            for (int c = 0; c < NCH; c++) begin
                nph = m_ph[c]; cap = 1'b0; val = 1; lovf = 1'b0; dt = cyc - m_t0[c];
                if (m_ph[c] == 0 && start[c]) begin
                    m_t0[c] = cyc;
                    if (done[c]) begin cap = 1'b1; val = 1; nph = cont[c] ? 0 : 2; end
                    else nph = 1;
                end else if (m_ph[c] == 1) begin
                    lovf = (dt >= MAXV);
                    if (done[c]) begin
                        cap = 1'b1; val = (dt + 1 > MAXV) ? MAXV : dt + 1; nph = cont[c] ? 0 : 2;
                    end
                end else if (m_ph[c] == 2 && done[c] && cont[c]) begin
                    nph = 0;
                end
                act = (m_ph[c] != 0) || start[c];
                stl = stall[c] && (m_ph[c] == 1);
                if (clr) begin
                    model_clear(c);
                end else if (!freeze) begin
                    if (cap) begin
                        if (m_inv[c] == MAXV) m_sat[c] = 1'b1; else m_inv[c]++;
                        m_last[c] = val;
                        if (val < m_min[c]) m_min[c] = val;
                        if (val > m_max[c]) m_max[c] = val;
                    end
                    if (act)     begin if (m_act[c] == MAXV) m_sat[c] = 1'b1; else m_act[c]++; end
                    if (stl)     begin if (m_stl[c] == MAXV) m_sat[c] = 1'b1; else m_stl[c]++; end
                    if (iter[c]) begin if (m_itr[c] == MAXV) m_sat[c] = 1'b1; else m_itr[c]++; end
                    if (lovf) m_sat[c] = 1'b1;
                end
                m_ph[c] = nph;
            end
        end
    endtask

    // One clock: model consumes the driven inputs, then every DUT output is compared
    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        check("rd_valid", {63'h0, rd_valid}, {63'h0, exp_valid});
        check("rd_data", {32'h0, rd_data}, {32'h0, exp_data});
        check("any_sat", {63'h0, any_sat}, {63'h0, exp_any});
        cyc++;
    endtask

    task automatic idle();
        start = 4'h0; done = 4'h0; iter = 4'h0; stall = 4'h0; cont = 4'hF; ready = 4'h0;
        clr = 1'b0; freeze = 1'b0; rd_en = 1'b0; rd_ch = 4'h0; rd_sel = 3'd0;
        b_start = 4'h0; b_done = 4'h0; b_clr = 1'b0; b_freeze = 1'b0;
        b_rd_en = 1'b0; b_rd_ch = 4'h0; b_rd_sel = 3'd0;
    endtask

    task automatic lit(input string name, input int ch, input int sel, input longint want);
        rd_en = 1'b1; rd_ch = 4'(ch); rd_sel = 3'(sel);
        step();
        rd_en = 1'b0;
        check({name, "_valid"}, {63'h0, rd_valid}, 64'h1);
        check(name, {32'h0, rd_data}, want);
    endtask

    task automatic blit(input string name, input int ch, input int sel, input longint want);
        b_rd_en = 1'b1; b_rd_ch = 4'(ch); b_rd_sel = 3'(sel);
        step();
        b_rd_en = 1'b0;
        check({name, "_valid"}, {63'h0, b_rd_valid}, 64'h1);
        check(name, {48'h0, b_rd_data}, want);
    endtask

    task automatic txn(input int ch, input int lat, input int n_iter, input int n_stall, input bit clr_last);
        for (int r = 0; r < lat; r++) begin
            start[ch] = (r == 0);
            done[ch]  = (r == lat - 1);
            iter[ch]  = (r < n_iter);
            stall[ch] = (r >= 1 && r <= n_stall);
            clr       = clr_last && (r == lat - 1);
            step();
        end
        start[ch] = 1'b0; done[ch] = 1'b0; iter[ch] = 1'b0; stall[ch] = 1'b0; clr = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        check("reset_rd_valid", {63'h0, rd_valid}, 64'h0);
        check("reset_rd_data", {32'h0, rd_data}, 64'h0);
        lit("reset_min_lat", 0, 2, MAXV);
        lit("reset_inv", 0, 0, 0);

        txn(0, 10, 0, 0, 1'b0);
        step();
        lit("single_inv", 0, 0, 1);
        lit("single_last", 0, 1, 10);
        lit("single_min", 0, 2, 10);
        lit("single_max", 0, 3, 10);
        lit("single_active", 0, 4, 10);
        lit("single_status", 0, 7, 0);

        for (int r = 0; r < 8; r++) begin
            start[1] = (r == 0); done[1] = (r >= 3); cont[1] = (r == 7);
            rd_en = (r == 5); rd_ch = 4'd1; rd_sel = 3'd7;
            step();
            if (r == 5) check("bp_status_wait", {32'h0, rd_data}, 64'h2);
        end
        start[1] = 1'b0; done[1] = 1'b0; cont[1] = 1'b1; rd_en = 1'b0;
        lit("bp_last", 1, 1, 4);
        lit("bp_active", 1, 4, 8);

        txn(2, 70, 64, 7, 1'b0);
        step();
        txn(2, 65, 0, 0, 1'b0);
        step();
        txn(2, 80, 0, 0, 1'b0);
        step();
        lit("pipe_iter", 2, 6, 64);
        lit("pipe_stall", 2, 5, 7);
        lit("pipe_inv", 2, 0, 3);
        lit("pipe_min", 2, 2, 65);
        lit("pipe_max", 2, 3, 80);
        lit("pipe_last", 2, 1, 80);

        freeze = 1'b1;
        txn(0, 5, 0, 0, 1'b0);
        freeze = 1'b0;
        lit("freeze_inv", 0, 0, 1);
        lit("freeze_active", 0, 4, 10);
        txn(0, 6, 0, 0, 1'b1);
        lit("clr_done_inv", 0, 0, 0);
        lit("clr_min", 0, 2, MAXV);
        lit("clr_other_ch", 2, 6, 0);

        lit("oor_channel", NCH, 3, 0);
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        lit("rst_run_status", 3, 7, 0);
        lit("rst_run_active", 3, 4, 0);

        b_start[3] = 1'b1;
        step();
        b_start[3] = 1'b0;
        repeat (69999) step();
        blit("sat_active", 3, 4, 64'hFFFF);
        blit("sat_status", 3, 7, 5);
        check("sat_any_sat", {63'h0, b_any_sat}, 64'h1);
        b_done[3] = 1'b1;
        step();
        b_done[3] = 1'b0;
        b_clr = 1'b1;
        step();
        b_clr = 1'b0;
        blit("satclr_active", 3, 4, 0);
        blit("satclr_status", 3, 7, 0);
        blit("satclr_min", 3, 2, 64'hFFFF);
        check("satclr_any_sat", {63'h0, b_any_sat}, 64'h0);

        for (int k = 0; k < 5000; k++) begin
            rst_n = ($urandom_range(0, 699) != 0);
            for (int c = 0; c < NCH; c++) begin
                start[c] = ($urandom_range(0, 3) == 0);
                done[c]  = ($urandom_range(0, 5) == 0);
                cont[c]  = ($urandom_range(0, 3) != 0);
                iter[c]  = ($urandom_range(0, 1) == 1);
                stall[c] = ($urandom_range(0, 2) == 0);
                ready[c] = ($urandom_range(0, 1) == 1);
            end
            clr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) freeze = ~freeze;
            rd_en  = ($urandom_range(0, 1) == 1);
            rd_ch  = 4'($urandom_range(0, NCH + 1));
            rd_sel = 3'($urandom_range(0, 7));
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
